ex_wb_stage: RTL and testbench

- Registered pipeline stage directly downstream of the ALU.
- Captures the ALU result, zero and carry outputs, plus the destination-register tag, behind a valid/ready handshake with a 2-entry skid buffer.
- Holds the architectural Z/C flags register, committed when an entry leaves toward writeback.
- Upstream is never back-pressured combinationally; o_ready is a pure register output.

---
 rtl/ex_wb_stage_if.sv | 46 ++++
 rtl/ex_wb_stage.sv | 115 +++++++++++
 tb/tb_ex_wb_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ex_wb_stage_if.sv
// ex_wb_stage_if: bus between the ALU side, the EX/WB stage and writeback.
//   slave  : the stage itself (takes ALU entries, presents head + arch state)
//   master : the surrounding pipeline / testbench
// Signals: i_valid/o_ready upstream handshake, i_result/i_zero/i_cf/i_rd/
// i_we/i_flags_we entry payload, i_flush redirect, o_valid/i_ready downstream
// handshake, o_result/o_rd/o_we head entry, o_flag_z/o_flag_c architectural
// flags, o_count retired-entry counter.
`ifndef WORD
`define WORD 32
`endif

interface ex_wb_stage_if #(
  parameter int WIDTH = `WORD,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_result;
  logic             i_zero;
  logic             i_cf;
  logic [RD_W-1:0]  i_rd;
  logic             i_we;
  logic             i_flags_we;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic [RD_W-1:0]  o_rd;
  logic             o_we;
  logic             o_flag_z;
  logic             o_flag_c;
  logic [CNT_W-1:0] o_count;

  modport slave (
    input  i_valid, i_result, i_zero, i_cf, i_rd, i_we, i_flags_we,
    input  i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rd, o_we, o_flag_z, o_flag_c, o_count
  );

  modport master (
    output i_valid, i_result, i_zero, i_cf, i_rd, i_we, i_flags_we,
    output i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_rd, o_we, o_flag_z, o_flag_c, o_count
  );
endinterface

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: registered stage after the ALU. A 2-entry skid buffer (main
// register M drives the outputs, skid register S catches the one entry that
// can arrive after writeback stalls) keeps o_ready a pure flop output.
// Commits architectural Z/C flags and a retired-entry count when the head
// entry leaves toward writeback.
// Ports: i_clk, i_rst (sync, active high), bus (ex_wb_stage_if.slave).
`ifndef WORD
`define WORD 32
`endif

module ex_wb_stage #(
  parameter int WIDTH = `WORD,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input logic          i_clk,
  input logic          i_rst,
  ex_wb_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cf;
    logic [RD_W-1:0]  rd;
    logic             we;
    logic             flags_we;
  } entry_t;

  entry_t           m_q, s_q, m_d, s_d, in_e;
  logic             m_vld, s_vld, m_vld_d, s_vld_d;
  logic             rdy_q;
  logic             flag_z_q, flag_c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, pop;

  assign in_e = '{result:   bus.i_result,
                  zero:     bus.i_zero,
                  cf:       bus.i_cf,
                  rd:       bus.i_rd,
                  we:       bus.i_we,
                  flags_we: bus.i_flags_we};

  assign accept = bus.i_valid & rdy_q;
  assign pop    = m_vld & bus.i_ready;

  // Buffer movement. While S is valid rdy_q is low, so a pop that drains S
  // never coincides with an accept.
  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld;
    s_vld_d = s_vld;
    if (bus.i_flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (pop) begin
      if (s_vld) begin
        m_d     = s_q;
        s_vld_d = 1'b0;
      end else if (accept) begin
        m_d = in_e;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_vld) begin
        m_d     = in_e;
        m_vld_d = 1'b1;
      end else begin
        s_d     = in_e;
        s_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_q      <= '0;
      s_q      <= '0;
      m_vld    <= 1'b0;
      s_vld    <= 1'b0;
      rdy_q    <= 1'b1;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      m_vld <= m_vld_d;
      s_vld <= s_vld_d;
      // Ready is derived from next-state S occupancy so it never depends
      // combinationally on i_ready.
      rdy_q <= ~s_vld_d;
      // Commit happens even in a flush cycle: the head did leave.
      if (pop) begin
        if (m_q.flags_we) begin
          flag_z_q <= m_q.zero;
          flag_c_q <= m_q.cf;
        end
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.o_valid  = m_vld;
  assign bus.o_ready  = rdy_q;
  assign bus.o_result = m_q.result;
  assign bus.o_rd     = m_q.rd;
  assign bus.o_we     = m_vld & m_q.we;
  assign bus.o_flag_z = flag_z_q;
  assign bus.o_flag_c = flag_c_q;
  assign bus.o_count  = cnt_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;
  localparam int WIDTH = 32;
  localparam int RD_W  = 5;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_wb_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(CNT_W)) bus ();

  ex_wb_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cf;
    logic [RD_W-1:0]  rd;
    logic             we;
    logic             fwe;
  } ent_t;

  // Reference model: an order-preserving queue of at most two entries plus
  // the architectural state it retires into.
  ent_t             mq[$];
  logic             mz, mc;
  logic [CNT_W-1:0] mcnt;

  int checks = 0;
  int failures = 0;

  task automatic set_in(input logic v, input logic [WIDTH-1:0] r, input logic z,
                        input logic c, input logic [RD_W-1:0] d, input logic w,
                        input logic f);
    bus.i_valid = v; bus.i_result = r; bus.i_zero = z; bus.i_cf = c;
    bus.i_rd = d; bus.i_we = w; bus.i_flags_we = f;
  endtask

  // Advance one clock and update the model from the inputs held across it;
  // returns #1 after the edge so outputs are settled for sampling.
  task automatic tick();
    ent_t e;
    bit acc, pp;
    @(posedge clk);
    if (rst) begin
      mq.delete(); mz = 0; mc = 0; mcnt = '0;
    end else begin
      acc = bus.i_valid && (mq.size() < 2);
      pp  = (mq.size() > 0) && bus.i_ready;
      if (pp) begin
        if (mq[0].fwe) begin mz = mq[0].zero; mc = mq[0].cf; end
        mcnt = mcnt + 1'b1;
        void'(mq.pop_front());
      end
      if (bus.i_flush) mq.delete();
      else if (acc) begin
        e.result = bus.i_result; e.zero = bus.i_zero; e.cf = bus.i_cf;
        e.rd = bus.i_rd; e.we = bus.i_we; e.fwe = bus.i_flags_we;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; bus.i_flush = 0; bus.i_ready = 0;
    set_in(0, '0, 0, 0, '0, 0, 0);
    tick(); tick();
    rst = 0;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.o_ready); end
    checks++; if ({bus.o_flag_z, bus.o_flag_c} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b want=00", bus.o_flag_z, bus.o_flag_c); end
    checks++; if (bus.o_count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus.o_count); end
    checks++; if (bus.o_result !== '0 || bus.o_rd !== '0 || bus.o_we !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%0d/%b want=0/0/0", bus.o_result, bus.o_rd, bus.o_we); end
  endtask

  task automatic test_single();
    bus.i_ready = 1;
    set_in(1, 32'h5, 0, 1, 5'd3, 1, 1);
    tick();
    set_in(0, '0, 0, 0, '0, 0, 0);
    checks++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'h5 || bus.o_rd !== 5'd3) begin failures++; $display("FAIL single_head got=%b/%h/%0d want=1/5/3", bus.o_valid, bus.o_result, bus.o_rd); end
    checks++; if (bus.o_we !== 1'b1) begin failures++; $display("FAIL single_we got=%b want=1", bus.o_we); end
    tick();
    checks++; if (bus.o_flag_c !== 1'b1 || bus.o_flag_z !== 1'b0) begin failures++; $display("FAIL single_flags got=z%b c%b want=z0 c1", bus.o_flag_z, bus.o_flag_c); end
    checks++; if (bus.o_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d want=1", bus.o_count); end
    checks++; if (bus.o_valid !== 1'b0 || bus.o_we !== 1'b0) begin failures++; $display("FAIL single_drain got=%b/%b want=0/0", bus.o_valid, bus.o_we); end
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] c0;
    c0 = bus.o_count;
    bus.i_ready = 0;
    set_in(1, 32'hA1, 0, 0, 5'd1, 1, 0); tick();
    checks++; if (bus.o_result !== 32'hA1 || bus.o_ready !== 1'b1) begin failures++; $display("FAIL bp_a got=%h rdy=%b want=a1 rdy=1", bus.o_result, bus.o_ready); end
    set_in(1, 32'hB2, 0, 0, 5'd2, 1, 0); tick();
    checks++; if (bus.o_ready !== 1'b0 || bus.o_result !== 32'hA1) begin failures++; $display("FAIL bp_b rdy=%b head=%h want rdy=0 head=a1", bus.o_ready, bus.o_result); end
    set_in(1, 32'hC3, 0, 0, 5'd3, 1, 0); tick(); tick();
    checks++; if (bus.o_ready !== 1'b0 || bus.o_result !== 32'hA1) begin failures++; $display("FAIL bp_stall rdy=%b head=%h want rdy=0 head=a1", bus.o_ready, bus.o_result); end
    bus.i_ready = 1; tick();
    checks++; if (bus.o_result !== 32'hB2 || bus.o_rd !== 5'd2 || bus.o_ready !== 1'b1) begin failures++; $display("FAIL bp_out_b got=%h/%0d rdy=%b want=b2/2 rdy=1", bus.o_result, bus.o_rd, bus.o_ready); end
    tick();
    set_in(0, '0, 0, 0, '0, 0, 0);
    checks++; if (bus.o_result !== 32'hC3 || bus.o_valid !== 1'b1) begin failures++; $display("FAIL bp_out_c got=%h v=%b want=c3 v=1", bus.o_result, bus.o_valid); end
    tick();
    checks++; if (bus.o_valid !== 1'b0 || bus.o_count !== c0 + 16'd3) begin failures++; $display("FAIL bp_done v=%b cnt=%0d want v=0 cnt=%0d", bus.o_valid, bus.o_count, c0 + 16'd3); end
  endtask

  task automatic test_flags();
    logic z0, c0;
    z0 = bus.o_flag_z; c0 = bus.o_flag_c;
    bus.i_ready = 1;
    set_in(1, 32'h0, 1, ~c0, 5'd4, 0, 0); tick();
    set_in(0, '0, 0, 0, '0, 0, 0); tick();
    checks++; if (bus.o_flag_z !== z0 || bus.o_flag_c !== c0) begin failures++; $display("FAIL flags_gated got=z%b c%b want=z%b c%b", bus.o_flag_z, bus.o_flag_c, z0, c0); end
    set_in(1, 32'h0, 1, 0, 5'd5, 1, 1); tick();
    set_in(0, '0, 0, 0, '0, 0, 0); tick();
    checks++; if (bus.o_flag_z !== 1'b1 || bus.o_flag_c !== 1'b0) begin failures++; $display("FAIL flags_commit got=z%b c%b want=z1 c0", bus.o_flag_z, bus.o_flag_c); end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] c0;
    c0 = bus.o_count;
    bus.i_ready = 0;
    set_in(1, 32'h11, 0, 1, 5'd6, 1, 1); tick();
    set_in(1, 32'h22, 1, 1, 5'd7, 1, 1); tick();
    checks++; if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1) begin failures++; $display("FAIL flush_full rdy=%b v=%b want rdy=0 v=1", bus.o_ready, bus.o_valid); end
    bus.i_ready = 1; bus.i_flush = 1;
    set_in(1, 32'h33, 1, 0, 5'd8, 1, 1); tick();
    bus.i_flush = 0;
    set_in(0, '0, 0, 0, '0, 0, 0);
    checks++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_we !== 1'b0) begin failures++; $display("FAIL flush_clear v=%b rdy=%b we=%b want 0/1/0", bus.o_valid, bus.o_ready, bus.o_we); end
    checks++; if (bus.o_count !== c0 + 16'd1) begin failures++; $display("FAIL flush_count got=%0d want=%0d", bus.o_count, c0 + 16'd1); end
    checks++; if (bus.o_flag_z !== 1'b0 || bus.o_flag_c !== 1'b1) begin failures++; $display("FAIL flush_flags got=z%b c%b want=z0 c1", bus.o_flag_z, bus.o_flag_c); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped v=%b want=0", bus.o_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      // Upstream must hold a stalled offer steady.
      if (!(bus.i_valid && !bus.o_ready))
        set_in(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom));
      bus.i_ready = 1'($urandom_range(0, 2) != 0);
      bus.i_flush = 1'($urandom_range(0, 24) == 0);
      tick();
      checks++; if (bus.o_valid !== (mq.size() > 0) || bus.o_ready !== (mq.size() < 2)) begin failures++; $display("FAIL rnd_hs cyc=%0d v=%b rdy=%b want v=%b rdy=%b", i, bus.o_valid, bus.o_ready, mq.size() > 0, mq.size() < 2); end
      checks++; if (bus.o_we !== (mq.size() > 0 ? mq[0].we : 1'b0)) begin failures++; $display("FAIL rnd_we cyc=%0d got=%b", i, bus.o_we); end
      if (mq.size() > 0) begin
        checks++; if (bus.o_result !== mq[0].result || bus.o_rd !== mq[0].rd) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h/%0d want=%h/%0d", i, bus.o_result, bus.o_rd, mq[0].result, mq[0].rd); end
      end
      checks++; if (bus.o_flag_z !== mz || bus.o_flag_c !== mc || bus.o_count !== mcnt) begin failures++; $display("FAIL rnd_arch cyc=%0d got=z%b c%b n%0d want=z%b c%b n%0d", i, bus.o_flag_z, bus.o_flag_c, bus.o_count, mz, mc, mcnt); end
    end
    bus.i_flush = 0; bus.i_ready = 1;
    set_in(0, '0, 0, 0, '0, 0, 0);
    tick(); tick();
  endtask

  task automatic test_wrap_and_reset();
    rst = 1; tick(); rst = 0;
    bus.i_ready = 1; bus.i_flush = 0;
    for (int i = 0; i < 65535; i++) begin
      set_in(1, $urandom, 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    set_in(0, '0, 0, 0, '0, 0, 0); tick();
    checks++; if (bus.o_count !== 16'hFFFF || bus.o_count !== mcnt) begin failures++; $display("FAIL wrap_preload got=%0d want=65535", bus.o_count); end
    set_in(1, 32'h77, 1, 1, 5'd9, 1, 1); tick();
    set_in(0, '0, 0, 0, '0, 0, 0); tick();
    checks++; if (bus.o_count !== 16'd0) begin failures++; $display("FAIL wrap_zero got=%0d want=0", bus.o_count); end
    checks++; if (bus.o_flag_z !== 1'b1 || bus.o_flag_c !== 1'b1) begin failures++; $display("FAIL wrap_flags got=z%b c%b want=z1 c1", bus.o_flag_z, bus.o_flag_c); end
    bus.i_ready = 0;
    set_in(1, 32'h88, 0, 0, 5'd10, 1, 1); tick();
    set_in(0, '0, 0, 0, '0, 0, 0);
    bus.i_ready = 1; rst = 1; tick(); rst = 0;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_we !== 1'b0) begin failures++; $display("FAIL rst_mid v=%b rdy=%b we=%b want 0/1/0", bus.o_valid, bus.o_ready, bus.o_we); end
    checks++; if (bus.o_count !== 16'd0 || bus.o_flag_z !== 1'b0 || bus.o_flag_c !== 1'b0) begin failures++; $display("FAIL rst_mid_arch n=%0d z%b c%b want n0 z0 c0", bus.o_count, bus.o_flag_z, bus.o_flag_c); end
    tick();
    checks++; if (bus.o_count !== 16'd0 || bus.o_valid !== 1'b0) begin failures++; $display("FAIL rst_no_commit n=%0d v=%b want n0 v0", bus.o_count, bus.o_valid); end
  endtask

  initial begin
    mz = 0; mc = 0; mcnt = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_flags();
    test_flush();
    test_random();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
